// File: rtl/regfile_access_arbiter_if.sv
// rtl/regfile_access_arbiter_if.sv - requester and register-file signal bundle for regfile_access_arbiter
interface regfile_access_arbiter_if #(
  parameter int NREG = 12,
  parameter int DW   = 16,
  parameter int AW   = 4
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [NREG-1:0] read;
  logic [NREG-1:0] write;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rdata;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rdata,
    input  req_ready, read, write, wdata, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rdata,
    output req_ready, read, write, wdata, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// rtl/regfile_access_arbiter.sv - two-requester round-robin arbiter driving one-hot register-file strobes
module regfile_access_arbiter #(
  parameter int NREG = 12,
  parameter int DW   = 16,
  parameter int AW   = 4
) (
  input  logic                      clk,
  input  logic                      rstb,
  regfile_access_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, STROBE, CAPTURE} state_t;

  localparam logic [AW:0] NREG_L = (AW+1)'(NREG);

  state_t          state, state_nxt;
  logic            ptr, ptr_nxt;
  logic [1:0]      grant;
  logic            handshake;

  logic            g_id;
  logic            g_write;
  logic [AW-1:0]   g_addr;
  logic [DW-1:0]   g_wdata;
  logic            g_in_range;
  logic [NREG-1:0] g_dec;

  logic            own_id;
  logic            own_write;
  logic            own_err;

  logic [NREG-1:0] read_q, read_nxt;
  logic [NREG-1:0] write_q, write_nxt;
  logic [DW-1:0]   wdata_q, wdata_nxt;
  logic [1:0]      rsp_valid_q, rsp_valid_nxt;
  logic            rsp_err_q, rsp_err_nxt;

  // ptr names the last-granted requester (0 = A, 1 = B); on contention the other one wins
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign handshake = |grant;
  assign g_id      = grant[1];
  assign g_write   = bus.req_write[g_id];
  assign g_addr    = g_id ? bus.req_addr[2*AW-1:AW]  : bus.req_addr[AW-1:0];
  assign g_wdata   = g_id ? bus.req_wdata[2*DW-1:DW] : bus.req_wdata[DW-1:0];
  assign g_in_range = ({1'b0, g_addr} < NREG_L);

  always_comb begin
    g_dec = '0;
    for (int i = 0; i < NREG; i++) begin
      g_dec[i] = (g_addr == AW'(i));
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      ptr   <= 1'b1;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Strobes are decoded from the granted request at the handshake edge so they leave a register
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    read_nxt      = '0;
    write_nxt     = '0;
    wdata_nxt     = wdata_q;
    rsp_valid_nxt = 2'b00;
    rsp_err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_nxt = STROBE;
          ptr_nxt   = g_id;
          wdata_nxt = g_wdata;
          if (g_in_range) begin
            if (g_write) write_nxt = g_dec;
            else         read_nxt  = g_dec;
          end
        end
      end
      STROBE: begin
        state_nxt     = CAPTURE;
        rsp_valid_nxt = own_id ? 2'b10 : 2'b01;
        rsp_err_nxt   = own_err;
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      own_id      <= 1'b0;
      own_write   <= 1'b0;
      own_err     <= 1'b0;
      read_q      <= '0;
      write_q     <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
    end else begin
      if (handshake) begin
        own_id    <= g_id;
        own_write <= g_write;
        own_err   <= !g_in_range;
      end
      read_q      <= read_nxt;
      write_q     <= write_nxt;
      wdata_q     <= wdata_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_err_q   <= rsp_err_nxt;
    end
  end

  assign bus.req_ready = grant;
  assign bus.read      = read_q;
  assign bus.write     = write_q;
  assign bus.wdata     = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  // Register-file data arrives in CAPTURE, so it passes straight through for good reads only
  assign bus.rsp_rdata = (state == CAPTURE && !own_write && !own_err) ? bus.rdata : '0;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// tb/tb_regfile_access_arbiter.sv - scoreboard bench for regfile_access_arbiter
module tb_regfile_access_arbiter;
  localparam int NREG = 12;
  localparam int DW   = 16;
  localparam int AW   = 4;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    int              cyc;
    logic [NREG-1:0] rd;
    logic [NREG-1:0] wr;
    logic [DW-1:0]   wdata;
  } stb_t;

  typedef struct {
    int            cyc;
    logic [1:0]    id;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  regfile_access_arbiter_if #(.NREG(NREG), .DW(DW), .AW(AW)) bus ();

  regfile_access_arbiter #(.NREG(NREG), .DW(DW), .AW(AW)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  req_t          pend_a[$];
  req_t          pend_b[$];
  stb_t          sq[$];
  rsp_t          rq[$];
  logic [DW-1:0] model_mem[NREG];
  logic [DW-1:0] regfile[NREG];
  int            cyc = 0;
  int            busy_until = 0;
  int            hs_count = 0;
  logic          ptr_m = 1'b1;
  logic [1:0]    drv_valid = 2'b00;
  logic [1:0]    exp_ready = 2'b00;
  logic          exp_busy = 1'b0;
  bit            gap_en = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;

  logic [1:0]      rsp_log[$];
  int              rsp_cyc_log[$];
  logic [NREG-1:0] last_rd_stb, last_wr_stb;
  logic [DW-1:0]   last_wdata, last_rdata;
  logic [1:0]      last_rsp_valid;
  logic            last_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] model_grant(input logic [1:0] v, input logic p, input bit free);
    if (!free) return 2'b00;
    if (v == 2'b11) return p ? 2'b01 : 2'b10;
    return v;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.write = 1'($urandom_range(1));
    r.addr  = AW'($urandom_range(15));
    r.wdata = DW'($urandom);
    return r;
  endfunction

  function automatic int oh_idx(input logic [NREG-1:0] v);
    for (int i = 0; i < NREG; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_edge();
    logic [1:0] g;
    req_t r;
    stb_t s;
    rsp_t p;
    bit inr;
    g = model_grant(drv_valid, ptr_m, cyc >= busy_until);
    if (g != 2'b00) begin
      if (g[1]) r = pend_b.pop_front();
      else      r = pend_a.pop_front();
      inr     = (int'(r.addr) < NREG);
      s.cyc   = cyc;
      s.rd    = '0;
      s.wr    = '0;
      s.wdata = r.wdata;
      if (inr && r.write)  s.wr = NREG'(1) << r.addr;
      if (inr && !r.write) s.rd = NREG'(1) << r.addr;
      p.cyc   = cyc + 1;
      p.id    = g;
      p.rdata = (inr && !r.write) ? model_mem[r.addr] : '0;
      p.err   = !inr;
      if (inr && r.write) model_mem[r.addr] = r.wdata;
      sq.push_back(s);
      rq.push_back(p);
      ptr_m      = g[1];
      busy_until = cyc + 3;
      hs_count++;
    end
  endtask

  task automatic drive_inputs();
    req_t ha, hb;
    logic va, vb;
    va = (pend_a.size() != 0) && (!gap_en || $urandom_range(3) != 0);
    vb = (pend_b.size() != 0) && (!gap_en || $urandom_range(3) != 0);
    ha = va ? pend_a[0] : rand_req();
    hb = vb ? pend_b[0] : rand_req();
    bus.req_valid = {vb, va};
    bus.req_write = {hb.write, ha.write};
    bus.req_addr  = {hb.addr, ha.addr};
    bus.req_wdata = {hb.wdata, ha.wdata};
    drv_valid = {vb, va};
    exp_ready = model_grant(drv_valid, ptr_m, cyc + 1 >= busy_until);
    exp_busy  = (cyc + 1 < busy_until);
  endtask

  task automatic model_reset();
    ptr_m      = 1'b1;
    busy_until = 0;
    sq.delete();
    rq.delete();
    exp_ready  = model_grant(drv_valid, 1'b1, 1'b1);
    exp_busy   = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rstb) model_edge();
    drive_inputs();
  end

  stb_t ms;
  rsp_t mr;
  always @(negedge clk) begin
    if (!rstb) begin
      bus.rdata = '0;
    end else begin
      chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      chk("busy", 64'(bus.busy), 64'(exp_busy));
      if (sq.size() != 0 && sq[0].cyc == cyc) begin
        ms = sq.pop_front();
        chk("read_strobe", 64'(bus.read), 64'(ms.rd));
        chk("write_strobe", 64'(bus.write), 64'(ms.wr));
        chk("wdata", 64'(bus.wdata), 64'(ms.wdata));
        last_rd_stb = bus.read;
        last_wr_stb = bus.write;
        last_wdata  = bus.wdata;
      end else begin
        chk("strobe_when_idle", 64'({bus.read, bus.write}), 64'(0));
      end
      if (rq.size() != 0 && rq[0].cyc == cyc) begin
        mr = rq.pop_front();
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(mr.id));
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(mr.rdata));
        chk("rsp_err", 64'(bus.rsp_err), 64'(mr.err));
        last_rsp_valid = bus.rsp_valid;
        last_rdata     = bus.rsp_rdata;
        last_err       = bus.rsp_err;
        rsp_log.push_back(bus.rsp_valid);
        rsp_cyc_log.push_back(cyc);
      end else begin
        chk("rsp_valid_when_idle", 64'({bus.rsp_valid, bus.rsp_err}), 64'(0));
      end
      // Behave as the register file: writes land now, read data is presented for the next cycle
      if ($countones(bus.write) == 1) regfile[oh_idx(bus.write)] = bus.wdata;
      if ($countones(bus.read) == 1) bus.rdata = regfile[oh_idx(bus.read)];
      else                           bus.rdata = DW'($urandom);
    end
  end

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (pend_a.size() == 0 && pend_b.size() == 0 && sq.size() == 0 &&
          rq.size() == 0 && cyc + 1 >= busy_until) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_idle: timeout after %0d cycles, required drain", budget);
  endtask

  task automatic wait_hs(input int budget);
    int n;
    n = hs_count;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (hs_count != n) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_hs: no handshake within %0d cycles", budget);
  endtask

  task automatic reset_pulse(input string tag);
    rstb = 1'b0;
    model_reset();
    #1;
    chk({tag, "_read"}, 64'(bus.read), 64'(0));
    chk({tag, "_write"}, 64'(bus.write), 64'(0));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    #1;
    rstb = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      model_mem[i] = DW'($urandom);
      regfile[i]   = model_mem[i];
    end
    model_mem[3] = 16'h1234;
    regfile[3]   = 16'h1234;
    rstb = 1'b1;
    #1 rstb = 1'b0;
    #11;
    chk("rst_read", 64'(bus.read), 64'(0));
    chk("rst_write", 64'(bus.write), 64'(0));
    chk("rst_wdata", 64'(bus.wdata), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    #1 rstb = 1'b1;

    pend_a.push_back('{write: 1'b0, addr: 4'd3, wdata: 16'h5555});
    wait_idle(50);
    chk("single_read_strobe", 64'(last_rd_stb), 64'(12'h008));
    chk("single_read_owner", 64'(last_rsp_valid), 64'(2'b01));
    chk("single_read_rdata", 64'(last_rdata), 64'(16'h1234));
    chk("single_read_err", 64'(last_err), 64'(0));

    pend_b.push_back('{write: 1'b1, addr: 4'd11, wdata: 16'hBEEF});
    wait_idle(50);
    chk("single_write_strobe", 64'(last_wr_stb), 64'(12'h800));
    chk("single_write_wdata", 64'(last_wdata), 64'(16'hBEEF));
    chk("single_write_owner", 64'(last_rsp_valid), 64'(2'b10));
    chk("single_write_rdata", 64'(last_rdata), 64'(0));

    pend_a.push_back('{write: 1'b0, addr: 4'd12, wdata: 16'h0});
    wait_idle(50);
    chk("oor_strobes", 64'({last_rd_stb, last_wr_stb}), 64'(0));
    chk("oor_err", 64'(last_err), 64'(1));
    chk("oor_rdata", 64'(last_rdata), 64'(0));

    reset_pulse("idle_reset");
    rsp_log.delete();
    rsp_cyc_log.delete();
    pend_a.push_back('{write: 1'b0, addr: 4'd1, wdata: 16'h0});
    pend_a.push_back('{write: 1'b0, addr: 4'd2, wdata: 16'h0});
    pend_b.push_back('{write: 1'b1, addr: 4'd4, wdata: 16'hA5A5});
    pend_b.push_back('{write: 1'b1, addr: 4'd5, wdata: 16'h5A5A});
    wait_idle(100);
    chk("contention_count", 64'(rsp_log.size()), 64'(4));
    if (rsp_log.size() >= 4) begin
      chk("contention_grant0", 64'(rsp_log[0]), 64'(2'b01));
      chk("contention_grant1", 64'(rsp_log[1]), 64'(2'b10));
      chk("contention_grant2", 64'(rsp_log[2]), 64'(2'b01));
      chk("contention_grant3", 64'(rsp_log[3]), 64'(2'b10));
      for (int i = 1; i < 4; i++)
        chk("contention_spacing", 64'(rsp_cyc_log[i] - rsp_cyc_log[i-1]), 64'(3));
    end

    pend_a.push_back('{write: 1'b0, addr: 4'd5, wdata: 16'h0});
    wait_hs(20);
    reset_pulse("abort");
    rsp_log.delete();
    pend_a.push_back('{write: 1'b0, addr: 4'd1, wdata: 16'h0});
    pend_b.push_back('{write: 1'b0, addr: 4'd2, wdata: 16'h0});
    wait_idle(50);
    chk("abort_rsp_count", 64'(rsp_log.size()), 64'(2));
    if (rsp_log.size() >= 1)
      chk("abort_first_grant", 64'(rsp_log[0]), 64'(2'b01));

    gap_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i % 2 == 0) pend_a.push_back(rand_req());
      else            pend_b.push_back(rand_req());
    end
    wait_idle(3000);
    gap_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_access_arbiter.md
REGFILE_ACCESS_ARBITER -- requirements
Module: regfile_access_arbiter

Interface
REQ-001 Parameter NREG, default 12, number of registers (one-hot strobe width), range 1..16.
REQ-002 Parameter DW, default 16, data width.
REQ-003 Parameter AW, default 4, register address width; NREG SHALL be <= 2^AW.
REQ-004 Port list; all inputs and outputs are active-high unless noted.
- clk  input  1  single clock; all state on rising edge.
- rstb  input  1  asynchronous active-low reset.
- req_valid  input  2  per-requester access request; bit 0 is requester A, bit 1 is requester B.
- req_ready  output  2  per-requester acceptance.
- req_write  input  2  per-requester access type: 1 = write, 0 = read.
- req_addr  input  2*AW  per-requester register index; A in [AW-1:0].
- req_wdata  input  2*DW  per-requester write data; A in [DW-1:0].
- read  output  NREG  one-hot read strobe to the register file.
- write  output  NREG  one-hot write strobe to the register file.
- wdata  output  DW  write data to the register file.
- rdata  input  DW  register-file read data, valid the cycle after the read strobe.
- rsp_valid  output  2  one-cycle response pulse to the owning requester.
- rsp_rdata  output  DW  read data for the response; 0 for writes and errors.
- rsp_err  output  1  response error flag, qualified by rsp_valid.
- busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, STROBE and CAPTURE.
REQ-006 Transitions SHALL be:
- IDLE -> STROBE on a handshake (req_valid & req_ready).
- STROBE -> CAPTURE unconditionally.
- CAPTURE -> IDLE unconditionally.
REQ-007 req_ready SHALL be nonzero only in IDLE and SHALL be one-hot; it is a combinational function of req_valid and the priority pointer.
REQ-008 Arbitration SHALL be round-robin using a 1-bit pointer that names the last-granted requester.
- Only one requester valid: that requester SHALL be granted.
- Both valid: the requester not named by the pointer SHALL be granted.
REQ-009 The pointer SHALL update only on a handshake, to the granted requester.
REQ-010 On a handshake the block SHALL register the granted requester's id, write flag, address and wdata; later changes on the request inputs SHALL have no effect.
REQ-011 In STROBE, exactly one bit of read (read access) or write (write access) SHALL be high, at the registered address; wdata SHALL carry the registered data.
REQ-012 In every state other than STROBE, read and write SHALL be all-zero; wdata SHALL hold its last value.
REQ-013 In CAPTURE, rsp_valid SHALL pulse for exactly one cycle, on the bit of the owning requester only.
- Read: rsp_rdata = rdata sampled in that cycle.
- Write: rsp_rdata = 0.
REQ-014 An address >= NREG SHALL still traverse STROBE and CAPTURE, with the following behaviour:
- No strobe is asserted in STROBE.
- In CAPTURE, rsp_err = 1 and rsp_rdata = 0.
- rsp_err SHALL otherwise be 0.
REQ-015 Latency SHALL be fixed: handshake at edge N -> strobe in cycle N+1 -> rsp_valid in cycle N+2 -> next handshake possible at edge N+3. Peak throughput is one access per 3 cycles.
REQ-016 Requests arriving while busy SHALL be held off (req_ready = 0) and not dropped.
REQ-017 rsp_valid, rsp_err, read and write SHALL be driven from registers (glitch-free).

Reset
REQ-018 Asynchronous assertion of rstb SHALL immediately produce:
- state IDLE and pointer = B (so A wins the first contention);
- read, write, wdata, rsp_valid, rsp_rdata and rsp_err all 0;
- busy = 0.
REQ-019 Reset asserted mid-access SHALL abort the access; no strobe and no response for it SHALL appear after deassertion.
REQ-020 Deassertion SHALL be synchronous to clk; the first handshake is possible at the first rising edge with rstb high.

Verification
REQ-021 Single read: A reads addr 3, rdata = 0x1234 -> read = 0x008 for one cycle; rsp_valid = 01 two cycles after the handshake; rsp_rdata = 0x1234; rsp_err = 0.
REQ-022 Single write: B writes 0xBEEF to addr 11 -> write = 0x800 for one cycle; wdata = 0xBEEF; rsp_valid = 10; rsp_rdata = 0.
REQ-023 Contention: both requesters hold valid for 4 accesses after reset -> grants are A, B, A, B; each access spans exactly 3 cycles; no cycle has more than one strobe bit high.
REQ-024 Out of range: A reads addr 12 -> read and write stay 0; rsp_err = 1; rsp_rdata = 0.
REQ-025 Reset abort: rstb pulsed low during STROBE -> strobes clear immediately; no rsp_valid afterwards; the next contention is granted to A.
